// File: rtl/clk_div_multi.sv
// Multi-channel integer clock divider with shadowed, boundary-applied ratios and per-period ticks.
// Optional build macro CLK_DIV_DUTY_EN adds a per-channel programmable high-phase length.
module clk_div_multi #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned RATIO_WIDTH = 8
) (
  input  logic                          i_ref_clk,
  input  logic                          i_rst,
  input  logic [NUM_CH-1:0]             i_clk_en,
  input  logic [NUM_CH*RATIO_WIDTH-1:0] i_div_ratio,
  input  logic [NUM_CH-1:0]             i_ratio_load,
`ifdef CLK_DIV_DUTY_EN
  input  logic [NUM_CH*RATIO_WIDTH-1:0] i_high_cnt,
`endif
  output logic [NUM_CH-1:0]             o_div_clk,
  output logic [NUM_CH-1:0]             o_tick,
  output logic [NUM_CH-1:0]             o_pending
);

  typedef enum logic {ST_BYPASS, ST_RUN} state_t;

  localparam logic [RATIO_WIDTH-1:0] ONE = RATIO_WIDTH'(1);
  localparam logic [RATIO_WIDTH-1:0] TWO = RATIO_WIDTH'(2);

  state_t                 state    [NUM_CH];
  state_t                 state_nx [NUM_CH];
  logic [RATIO_WIDTH-1:0] shadow   [NUM_CH];
  logic [RATIO_WIDTH-1:0] shadow_nx[NUM_CH];
  logic [RATIO_WIDTH-1:0] r_act    [NUM_CH];
  logic [RATIO_WIDTH-1:0] r_act_nx [NUM_CH];
  logic [RATIO_WIDTH-1:0] cnt      [NUM_CH];
  logic [RATIO_WIDTH-1:0] cnt_nx   [NUM_CH];
  logic [RATIO_WIDTH-1:0] last     [NUM_CH];
  logic [RATIO_WIDTH-1:0] high_len [NUM_CH];
  logic [NUM_CH-1:0]      pending, pending_nx;
  logic [NUM_CH-1:0]      q, q_nx;
  logic [NUM_CH-1:0]      tick, tick_nx;
  logic [NUM_CH-1:0]      divide, at_end, apply;
`ifdef CLK_DIV_DUTY_EN
  logic [RATIO_WIDTH-1:0] high_sh    [NUM_CH];
  logic [RATIO_WIDTH-1:0] high_sh_nx [NUM_CH];
  logic [RATIO_WIDTH-1:0] high_act   [NUM_CH];
  logic [RATIO_WIDTH-1:0] high_act_nx[NUM_CH];
`endif

  // Per-channel decode of the currently applied ratio.
  always_comb begin
    divide = '0;
    at_end = '0;
    apply  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      last[c]     = r_act[c] - ONE;
      high_len[c] = (r_act[c] >> 1) + (r_act[c][0] ? ONE : '0);
`ifdef CLK_DIV_DUTY_EN
      if (high_act[c] != '0)
        high_len[c] = (high_act[c] > last[c]) ? last[c] : high_act[c];
`endif
      divide[c] = i_clk_en[c] && (r_act[c] >= TWO);
      at_end[c] = (state[c] == ST_RUN) && (cnt[c] == last[c]);
      apply[c]  = pending[c] && ((state[c] == ST_BYPASS) || at_end[c]);
    end
  end

  // Next-state: counter/phase sequencing plus shadow load and boundary apply.
  always_comb begin
    pending_nx = pending;
    q_nx       = q;
    tick_nx    = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      state_nx[c]  = state[c];
      cnt_nx[c]    = cnt[c];
      shadow_nx[c] = shadow[c];
      r_act_nx[c]  = r_act[c];
`ifdef CLK_DIV_DUTY_EN
      high_sh_nx[c]  = high_sh[c];
      high_act_nx[c] = high_act[c];
`endif
      if (!divide[c]) begin
        state_nx[c] = ST_BYPASS;
        cnt_nx[c]   = '0;
        q_nx[c]     = 1'b0;
      end else if (state[c] == ST_BYPASS) begin
        state_nx[c] = ST_RUN;
        cnt_nx[c]   = '0;
        q_nx[c]     = 1'b1;
      end else begin
        cnt_nx[c] = at_end[c] ? '0 : cnt[c] + ONE;
        q_nx[c]   = cnt_nx[c] < high_len[c];
      end
      tick_nx[c] = (state_nx[c] == ST_RUN) && (cnt_nx[c] == '0);

      // Apply reads the old shadow, so a coincident load stays pending for the next boundary.
      if (apply[c]) begin
        r_act_nx[c]   = shadow[c];
        pending_nx[c] = 1'b0;
`ifdef CLK_DIV_DUTY_EN
        high_act_nx[c] = high_sh[c];
`endif
      end
      if (i_ratio_load[c]) begin
        shadow_nx[c]  = i_div_ratio[c*RATIO_WIDTH +: RATIO_WIDTH];
        pending_nx[c] = 1'b1;
`ifdef CLK_DIV_DUTY_EN
        high_sh_nx[c] = i_high_cnt[c*RATIO_WIDTH +: RATIO_WIDTH];
`endif
      end
    end
  end

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      pending <= '0;
      q       <= '0;
      tick    <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state[c]  <= ST_BYPASS;
        cnt[c]    <= '0;
        shadow[c] <= '0;
        r_act[c]  <= '0;
`ifdef CLK_DIV_DUTY_EN
        high_sh[c]  <= '0;
        high_act[c] <= '0;
`endif
      end
    end else begin
      pending <= pending_nx;
      q       <= q_nx;
      tick    <= tick_nx;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state[c]  <= state_nx[c];
        cnt[c]    <= cnt_nx[c];
        shadow[c] <= shadow_nx[c];
        r_act[c]  <= r_act_nx[c];
`ifdef CLK_DIV_DUTY_EN
        high_sh[c]  <= high_sh_nx[c];
        high_act[c] <= high_act_nx[c];
`endif
      end
    end
  end

  // Bypass mux is selected by the registered run state only.
  always_comb begin
    o_div_clk = '0;
    for (int unsigned c = 0; c < NUM_CH; c++)
      o_div_clk[c] = (state[c] == ST_RUN) ? q[c] : i_ref_clk;
    o_tick    = tick;
    o_pending = pending;
  end

endmodule
